// File: rtl/regfile_pkg.sv
// Shared types and widths for the register-file write-back path.
package regfile_pkg;

    localparam int REG_ADDR_W = 3;
    localparam int REG_DATA_W = 8;
    localparam int NUM_REGS   = 8;
    localparam int WB_ENTRY_W = REG_ADDR_W + REG_DATA_W;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] reg_addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_e;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] v;
        v       = '0;
        v[addr] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/regfile_writeback_fifo.sv
// Circular buffer of pending register writes; exposes every slot plus a
// per-slot valid vector so the parent can build the pending-write mask.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_push,
    input  logic [WB_ENTRY_W-1:0]       i_push_data,
    input  logic                        i_pop,
    output logic [WB_ENTRY_W-1:0]       o_head,
    output logic [DEPTH-1:0]            o_valid,
    output logic [DEPTH*WB_ENTRY_W-1:0] o_entries,
    output logic                        o_full,
    output logic                        o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WB_ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [DEPTH-1:0]      r_valid;

    logic                  w_do_pop;
    logic                  w_do_push;
    logic [DEPTH-1:0]      w_valid_next;

    assign o_full   = (r_count == CNT_W'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_head   = r_mem[r_rd_ptr];
    assign o_valid  = r_valid;

    // A push into a full buffer is legal only when the head leaves in the same cycle.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_comb begin
        w_valid_next = r_valid;
        if (w_do_pop)
            w_valid_next[r_rd_ptr] = 1'b0;
        if (w_do_push)
            w_valid_next[r_wr_ptr] = 1'b1;
    end

    always_comb begin
        o_entries = '0;
        for (int i = 0; i < DEPTH; i++)
            o_entries[i*WB_ENTRY_W +: WB_ENTRY_W] = r_mem[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            r_valid <= w_valid_next;
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Write-back front end: round-robin ALU/load arbiter, write FIFO, registered
// write port and pending-write mask. Define WB_R0_DISCARD_EN to make r0 read-only zero.
module regfile_writeback
    import regfile_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [ADDR_W-1:0]   alu_reg,
    input  logic [DATA_W-1:0]   alu_data,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [ADDR_W-1:0]   mem_reg,
    input  logic [DATA_W-1:0]   mem_data,
    input  logic                wb_hold,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_reg,
    output logic [DATA_W-1:0]   wr_data,
    output logic [NUM_REGS-1:0] pending,
    output logic                full
);

    // Handshake: a source's result is taken at the rising edge where its
    // valid and ready are both high; an un-taken offer must be held stable.

    wb_src_e                      r_rr_last;
    logic                         r_wr_en;
    logic [ADDR_W-1:0]            r_wr_reg;
    logic [DATA_W-1:0]            r_wr_data;

    logic                         w_grant_alu;
    logic                         w_grant_mem;
    logic                         w_pop;
    logic                         w_can_push;
    logic                         w_discard;
    logic                         w_accept;
    logic                         w_push;
    wb_entry_t                    w_push_entry;
    wb_entry_t                    w_head;
    logic                         w_fifo_full;
    logic                         w_fifo_empty;
    logic [DEPTH-1:0]             w_valid;
    logic [DEPTH*WB_ENTRY_W-1:0]  w_entries;
    logic [NUM_REGS-1:0]          w_pend;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_valid     (w_valid),
        .o_entries   (w_entries),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    always_comb begin
        // On contention the source that lost the previous acceptance goes first.
        w_grant_alu = alu_valid & (~mem_valid | (r_rr_last == SRC_MEM));
        w_grant_mem = mem_valid & (~alu_valid | (r_rr_last == SRC_ALU));
        w_pop       = ~wb_hold & ~w_fifo_empty;
        w_can_push  = ~w_fifo_full | w_pop;

        w_push_entry.reg_addr = w_grant_mem ? mem_reg  : alu_reg;
        w_push_entry.data     = w_grant_mem ? mem_data : alu_data;
`ifdef WB_R0_DISCARD_EN
        w_discard = (w_push_entry.reg_addr == '0);
`else
        w_discard = 1'b0;
`endif
        w_accept  = (w_grant_alu | w_grant_mem) & (w_can_push | w_discard);
        alu_ready = w_grant_alu & w_accept;
        mem_ready = w_grant_mem & w_accept;
        w_push    = w_accept & ~w_discard;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_wr_reg  <= '0;
            r_wr_data <= '0;
            r_rr_last <= SRC_ALU;
        end else begin
            r_wr_en <= w_pop;
            if (w_pop) begin
                r_wr_reg  <= w_head.reg_addr;
                r_wr_data <= w_head.data;
            end
            if (alu_ready)
                r_rr_last <= SRC_ALU;
            else if (mem_ready)
                r_rr_last <= SRC_MEM;
        end
    end

    always_comb begin
        wb_entry_t w_ent;
        w_ent  = '0;
        w_pend = r_wr_en ? reg_onehot(r_wr_reg) : '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_ent = w_entries[i*WB_ENTRY_W +: WB_ENTRY_W];
            if (w_valid[i])
                w_pend = w_pend | reg_onehot(w_ent.reg_addr);
        end
    end

`ifdef WB_R0_DISCARD_EN
    assign pending = w_pend & ~NUM_REGS'(1);
`else
    assign pending = w_pend;
`endif

    assign wr_en   = r_wr_en;
    assign wr_reg  = r_wr_reg;
    assign wr_data = r_wr_data;
    assign full    = w_fifo_full;

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios then random traffic, every
// cycle compared against a queue-based model of the write-back path.
module tb_regfile_writeback;

    localparam int DEPTH = 4;
`ifdef WB_R0_DISCARD_EN
    localparam bit DISCARD = 1'b1;
`else
    localparam bit DISCARD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       alu_valid, alu_ready, mem_valid, mem_ready, wb_hold;
    logic [2:0] alu_reg, mem_reg, wr_reg;
    logic [7:0] alu_data, mem_data, wr_data, pending;
    logic       wr_en, full;

    always #5 clk = ~clk;

    regfile_writeback dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_reg   (alu_reg),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_reg   (mem_reg),
        .mem_data  (mem_data),
        .wb_hold   (wb_hold),
        .wr_en     (wr_en),
        .wr_reg    (wr_reg),
        .wr_data   (wr_data),
        .pending   (pending),
        .full      (full)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: writes waiting to retire, in acceptance order, plus the write port.
    logic [10:0] exp_q[$];
    logic        out_valid;
    logic [2:0]  out_reg;
    logic [7:0]  out_data;
    logic        rr_last;  // 0: ALU won last, 1: MEM won last

    logic       s_alu_ready, s_mem_ready, s_full, s_wr_en;
    logic [7:0] s_pending;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        out_valid = 1'b0;
        out_reg   = '0;
        out_data  = '0;
        rr_last   = 1'b0;
    endtask

    function automatic logic [7:0] model_pending();
        logic [7:0]  p;
        logic [10:0] e;
        p = '0;
        foreach (exp_q[i]) begin
            e = exp_q[i];
            p[e[10:8]] = 1'b1;
        end
        if (out_valid)
            p[out_reg] = 1'b1;
        if (DISCARD)
            p[0] = 1'b0;
        return p;
    endfunction

    function automatic logic is_discard(input logic [2:0] r);
        return DISCARD && (r == 3'd0);
    endfunction

    // One clock cycle: drive just after a rising edge, compare at the falling
    // edge, then advance the model across the next rising edge.
    task automatic cyc(input logic av, input logic [2:0] ar, input logic [7:0] ad,
                       input logic mv, input logic [2:0] mr, input logic [7:0] md,
                       input logic hold, output logic acc_a, output logic acc_m);
        int   size;
        logic g_a, g_m, pop, canp, e_ar, e_am;
        alu_valid = av; alu_reg = ar; alu_data = ad;
        mem_valid = mv; mem_reg = mr; mem_data = md;
        wb_hold   = hold;
        #4;
        size = exp_q.size();
        g_a  = av && (!mv || rr_last);
        g_m  = mv && (!av || !rr_last);
        pop  = !hold && (size > 0);
        canp = (size < DEPTH) || pop;
        e_ar = g_a && (canp || is_discard(ar));
        e_am = g_m && (canp || is_discard(mr));
        s_alu_ready = alu_ready; s_mem_ready = mem_ready; s_full = full;
        s_wr_en = wr_en; s_pending = pending;
        check("alu_ready", 32'(alu_ready), 32'(e_ar));
        check("mem_ready", 32'(mem_ready), 32'(e_am));
        check("full",      32'(full),      32'(size == DEPTH));
        check("pending",   32'(pending),   32'(model_pending()));
        check("wr_en",     32'(wr_en),     32'(out_valid));
        check("wr_reg",    32'(wr_reg),    32'(out_reg));
        check("wr_data",   32'(wr_data),   32'(out_data));
        @(posedge clk);
        if (pop) begin
            {out_reg, out_data} = exp_q.pop_front();
            out_valid = 1'b1;
        end else begin
            out_valid = 1'b0;
        end
        if (e_ar) begin
            rr_last = 1'b0;
            if (!is_discard(ar)) exp_q.push_back({ar, ad});
        end
        if (e_am) begin
            rr_last = 1'b1;
            if (!is_discard(mr)) exp_q.push_back({mr, md});
        end
        acc_a = e_ar;
        acc_m = e_am;
        #1;
    endtask

    task automatic idle(input int n, input logic hold);
        logic a, m;
        for (int i = 0; i < n; i++)
            cyc(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0, hold, a, m);
    endtask

    initial begin
        logic       acc_a, acc_m, a_v, m_v, hold;
        logic [2:0] a_r, m_r;
        logic [7:0] a_d, m_d;

        rst = 1'b1;
        alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
        mem_valid = 1'b0; mem_reg = '0; mem_data = '0;
        wb_hold = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_wr_en",   32'(wr_en),   32'(0));
        check("rst_wr_reg",  32'(wr_reg),  32'(0));
        check("rst_wr_data", 32'(wr_data), 32'(0));
        check("rst_pending", 32'(pending), 32'(0));
        check("rst_full",    32'(full),    32'(0));
        rst = 1'b0;

        // Single ALU write r3 = 0x5A
        cyc(1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'd0, 1'b0, acc_a, acc_m);
        check("t1_alu_ready", 32'(s_alu_ready), 32'(1));
        idle(1, 1'b0);
        check("t1_pend3", 32'(s_pending[3]), 32'(1));
        idle(1, 1'b0);
        check("t1_wr_en", 32'(s_wr_en), 32'(1));
        idle(2, 1'b0);

        // Both sources valid: MEM first, then alternate
        a_r = 3'd1; a_d = 8'hA1; m_r = 3'd2; m_d = 8'hB1;
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, a_r, a_d, 1'b1, m_r, m_d, 1'b0, acc_a, acc_m);
            check("t2_mem_ready", 32'(s_mem_ready), 32'(k % 2 == 0));
            check("t2_alu_ready", 32'(s_alu_ready), 32'(k % 2 == 1));
            if (acc_a) begin a_r = a_r + 3'd2; a_d = a_d + 8'd1; end
            if (acc_m) begin m_r = m_r + 3'd2; m_d = m_d + 8'd1; end
        end
        idle(4, 1'b0);

        // Held write port: fill r1..r4, r5 refused, then release
        for (int i = 1; i <= 4; i++)
            cyc(1'b1, 3'(i), 8'(16 + i), 1'b0, 3'd0, 8'd0, 1'b1, acc_a, acc_m);
        cyc(1'b1, 3'd5, 8'h15, 1'b0, 3'd0, 8'd0, 1'b1, acc_a, acc_m);
        check("t3_alu_ready", 32'(s_alu_ready), 32'(0));
        check("t3_full",      32'(s_full),      32'(1));
        check("t3_pending",   32'(s_pending),   32'(8'b0001_1110));
        cyc(1'b1, 3'd5, 8'h15, 1'b0, 3'd0, 8'd0, 1'b0, acc_a, acc_m);
        check("t3_accept_r5", 32'(s_alu_ready), 32'(1));
        idle(7, 1'b0);

        // Full FIFO, hold drops in the same cycle as a new offer
        cyc(1'b1, 3'd6, 8'h66, 1'b0, 3'd0, 8'd0, 1'b1, acc_a, acc_m);
        cyc(1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 8'h77, 1'b1, acc_a, acc_m);
        cyc(1'b1, 3'd1, 8'h11, 1'b0, 3'd0, 8'd0, 1'b1, acc_a, acc_m);
        cyc(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 8'h22, 1'b1, acc_a, acc_m);
        cyc(1'b1, 3'd3, 8'h33, 1'b0, 3'd0, 8'd0, 1'b0, acc_a, acc_m);
        check("t4_accept", 32'(s_alu_ready), 32'(1));
        idle(1, 1'b1);
        check("t4_full_kept", 32'(s_full), 32'(1));
        idle(7, 1'b0);

        // Reset with writes queued and one on the port
        cyc(1'b1, 3'd4, 8'h44, 1'b0, 3'd0, 8'd0, 1'b1, acc_a, acc_m);
        cyc(1'b1, 3'd5, 8'h55, 1'b0, 3'd0, 8'd0, 1'b1, acc_a, acc_m);
        cyc(1'b1, 3'd6, 8'h66, 1'b0, 3'd0, 8'd0, 1'b1, acc_a, acc_m);
        idle(1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("t5_wr_en",   32'(wr_en),   32'(0));
        check("t5_pending", 32'(pending), 32'(0));
        check("t5_full",    32'(full),    32'(0));
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(5, 1'b0);

        // Write to r0
        cyc(1'b1, 3'd0, 8'hFF, 1'b0, 3'd0, 8'd0, 1'b0, acc_a, acc_m);
        check("t6_accept", 32'(s_alu_ready), 32'(1));
        idle(2, 1'b0);
        check("t6_wr_en", 32'(s_wr_en), DISCARD ? 32'(0) : 32'(1));
        idle(2, 1'b0);

        // Random traffic; an offer stays stable until it is taken
        a_v = 1'b0; m_v = 1'b0; acc_a = 1'b0; acc_m = 1'b0;
        a_r = '0; a_d = '0; m_r = '0; m_d = '0;
        for (int n = 0; n < 400; n++) begin
            if (!a_v || acc_a) begin
                a_v = ($urandom_range(0, 3) != 0);
                a_r = 3'($urandom_range(0, 7));
                a_d = 8'($urandom_range(0, 255));
            end
            if (!m_v || acc_m) begin
                m_v = ($urandom_range(0, 2) != 0);
                m_r = 3'($urandom_range(0, 7));
                m_d = 8'($urandom_range(0, 255));
            end
            hold = ($urandom_range(0, 9) < 3);
            cyc(a_v, a_r, a_d, m_v, m_r, m_d, hold, acc_a, acc_m);
        end
        idle(8, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
